alu_share_arbiter: RTL and testbench

//  Shares one ALU instance between the two issue slots (slot0 = older, slot1 = younger) of the dual-issue core.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu.sv | 40 ++++
 rtl/rr_arb2.sv | 17 +
 rtl/alu_share_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the dual-slot ALU arbiter: opcodes, request bundle,
// slot ids and the round-robin preference states.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SGT = 4'd9;

  localparam int SLOT0 = 0;
  localparam int SLOT1 = 1;

  // Tag field is sized for the widest tag any instance may use.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [3:0]           aluop;
    logic signed [31:0]   op1;
    logic signed [31:0]   op2;
    logic [4:0]           shamt;
    logic [TAG_MAX_W-1:0] tag;
  } alu_req_t;

  typedef enum logic {PREF0 = 1'b0, PREF1 = 1'b1} pref_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by both issue slots.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]         aluop,
  input  logic signed [31:0] op1,
  input  logic signed [31:0] op2,
  input  logic [4:0]         shamt,
  output logic signed [31:0] result,
  output logic               ovf
);

  // Same-sign operands producing an opposite-sign result; evaluated for every
  // opcode, the consumer decides whether it is meaningful.
  function automatic logic ovf_calc(input logic signed [31:0] a,
                                    input logic signed [31:0] b,
                                    input logic signed [31:0] r);
    return (r[31] & ~a[31] & ~b[31]) | (~r[31] & a[31] & b[31]);
  endfunction

  always_comb begin
    result = '0;
    case (aluop)
      ALU_ADD: result = op1 + op2;
      ALU_SUB: result = op1 - op2;
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      ALU_XOR: result = op1 ^ op2;
      ALU_NOR: result = ~(op1 | op2);
      ALU_SLT: result = (op1 < op2) ? 32'sd1 : 32'sd0;
      ALU_SLL: result = op2 << shamt;
      ALU_SRL: result = signed'(unsigned'(op2) >> shamt);
      ALU_SGT: result = (op1 > op2) ? 32'sd1 : 32'sd0;
      default: result = '0;
    endcase
  end

  assign ovf = ovf_calc(op1, op2, result);

endmodule

// File: rtl/rr_arb2.sv
// Two-way picker: a lone requester wins; on contention the pointer slot wins
// unless fixed priority pins the win to slot0.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       fixed,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr && !fixed) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the two issue slots; grants one slot per cycle and
// returns the registered result on that slot's response one cycle later.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_aluop0,
  input  logic [3:0]         req_aluop1,
  input  logic signed [31:0] req_op1_0,
  input  logic signed [31:0] req_op1_1,
  input  logic signed [31:0] req_op2_0,
  input  logic signed [31:0] req_op2_1,
  input  logic [4:0]         req_shamt0,
  input  logic [4:0]         req_shamt1,
  input  logic [TAG_W-1:0]   req_tag0,
  input  logic [TAG_W-1:0]   req_tag1,
  output logic [1:0]         rsp_valid,
  output logic signed [31:0] rsp_result,
  output logic               rsp_ovf,
  output logic [TAG_W-1:0]   rsp_tag
);

  pref_e              state;
  pref_e              state_nxt;
  logic               ptr;
  logic [1:0]         gnt_raw;
  logic [1:0]         gnt_p0;
  alu_req_t           req0;
  alu_req_t           req1;
  alu_req_t           sel_p0;
  logic signed [31:0] alu_res_p0;
  logic               alu_ovf_p0;

  logic [1:0]         vld_p1;
  logic signed [31:0] result_p1;
  logic               ovf_p1;
  logic [TAG_W-1:0]   tag_p1;

  always_comb begin
    req0.aluop = req_aluop0;
    req0.op1   = req_op1_0;
    req0.op2   = req_op2_0;
    req0.shamt = req_shamt0;
    req0.tag   = TAG_MAX_W'(req_tag0);
    req1.aluop = req_aluop1;
    req1.op1   = req_op1_1;
    req1.op2   = req_op2_1;
    req1.shamt = req_shamt1;
    req1.tag   = TAG_MAX_W'(req_tag1);
  end

  assign ptr = FIXED_PRIO ? 1'b0 : (state == PREF1);

  rr_arb2 u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .fixed (FIXED_PRIO),
    .gnt   (gnt_raw)
  );

  // Reset and flush both suppress acceptance, which also keeps rr_ptr still.
  assign gnt_p0    = (reset || flush) ? 2'b00 : gnt_raw;
  assign req_ready = gnt_p0;
  assign sel_p0    = gnt_p0[1] ? req1 : req0;

  alu u_alu (
    .aluop  (sel_p0.aluop),
    .op1    (sel_p0.op1),
    .op2    (sel_p0.op2),
    .shamt  (sel_p0.shamt),
    .result (alu_res_p0),
    .ovf    (alu_ovf_p0)
  );

  always_comb begin
    state_nxt = state;
    if (!FIXED_PRIO) begin
      if (gnt_p0[SLOT0]) begin
        state_nxt = PREF1;
      end else if (gnt_p0[SLOT1]) begin
        state_nxt = PREF0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PREF0;
    end else begin
      state <= state_nxt;
    end
  end

  // p0 -> p1: response register; data holds when nothing is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 2'b00;
      result_p1 <= '0;
      ovf_p1    <= 1'b0;
      tag_p1    <= '0;
    end else begin
      vld_p1 <= gnt_p0;
      if (|gnt_p0) begin
        result_p1 <= alu_res_p0;
        ovf_p1    <= alu_ovf_p0;
        tag_p1    <= sel_p0.tag[TAG_W-1:0];
      end
    end
  end

  assign rsp_valid  = vld_p1;
  assign rsp_result = result_p1;
  assign rsp_ovf    = ovf_p1;
  assign rsp_tag    = tag_p1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin and a fixed-priority instance
// share stimulus and are compared against a behavioural model.
module tb_alu_share_arbiter;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic [1:0]         req_valid;
  logic [3:0]         aluop0, aluop1;
  logic signed [31:0] op1_0, op1_1, op2_0, op2_1;
  logic [4:0]         shamt0, shamt1;
  logic [3:0]         tag0, tag1;

  logic [1:0]         ready_a, rsp_valid_a;
  logic signed [31:0] result_a;
  logic               ovf_a;
  logic [3:0]         tag_a;
  logic [1:0]         ready_b, rsp_valid_b;
  logic signed [31:0] result_b;
  logic               ovf_b;
  logic [3:0]         tag_b;

  int total = 0;
  int bad   = 0;

  int          m_pref;
  logic [1:0]  e_vld [2];
  logic [31:0] e_res [2];
  logic        e_ovf [2];
  logic [3:0]  e_tag [2];

  always #5 clk = ~clk;

  alu_share_arbiter #(.TAG_W(4), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(ready_a),
    .req_aluop0(aluop0), .req_aluop1(aluop1), .req_op1_0(op1_0), .req_op1_1(op1_1),
    .req_op2_0(op2_0), .req_op2_1(op2_1), .req_shamt0(shamt0), .req_shamt1(shamt1),
    .req_tag0(tag0), .req_tag1(tag1), .rsp_valid(rsp_valid_a), .rsp_result(result_a),
    .rsp_ovf(ovf_a), .rsp_tag(tag_a)
  );

  alu_share_arbiter #(.TAG_W(4), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(ready_b),
    .req_aluop0(aluop0), .req_aluop1(aluop1), .req_op1_0(op1_0), .req_op1_1(op1_1),
    .req_op2_0(op2_0), .req_op2_1(op2_1), .req_shamt0(shamt0), .req_shamt1(shamt1),
    .req_tag0(tag0), .req_tag1(tag1), .rsp_valid(rsp_valid_b), .rsp_result(result_b),
    .rsp_ovf(ovf_b), .rsp_tag(tag_b)
  );

  function automatic logic [1:0] model_gnt(logic [1:0] v, int pref, logic fl, logic rs);
    if (rs || fl) return 2'b00;
    if (v == 2'b11) return (pref == 0) ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic logic [31:0] m_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return b << sh;
      4'd8: return b >> sh;
      4'd9: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_ovf(logic [31:0] a, logic [31:0] b, logic [31:0] r);
    return (r[31] & ~a[31] & ~b[31]) | (~r[31] & a[31] & b[31]);
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Advance one clock, updating the expected state of both instances.
  task automatic clk_step();
    logic [1:0]  n_vld [2];
    logic [31:0] n_res [2];
    logic        n_ovf [2];
    logic [3:0]  n_tag [2];
    int          n_pref;
    n_pref = m_pref;
    for (int d = 0; d < 2; d++) begin
      logic [1:0]  g;
      logic [31:0] a, b;
      logic [3:0]  op, tg;
      logic [4:0]  sh;
      g = model_gnt(req_valid, (d == 0) ? m_pref : 0, flush, reset);
      n_vld[d] = g;
      n_res[d] = e_res[d];
      n_ovf[d] = e_ovf[d];
      n_tag[d] = e_tag[d];
      if (reset) begin
        n_res[d] = 32'h0;
        n_ovf[d] = 1'b0;
        n_tag[d] = 4'h0;
      end else if (g != 2'b00) begin
        if (g[1]) begin
          op = aluop1; a = op1_1; b = op2_1; sh = shamt1; tg = tag1;
        end else begin
          op = aluop0; a = op1_0; b = op2_0; sh = shamt0; tg = tag0;
        end
        n_res[d] = m_alu(op, a, b, sh);
        n_ovf[d] = m_ovf(a, b, n_res[d]);
        n_tag[d] = tg;
        if (d == 0) n_pref = g[1] ? 0 : 1;
      end
    end
    if (reset) n_pref = 0;
    @(posedge clk);
    m_pref = n_pref;
    for (int d = 0; d < 2; d++) begin
      e_vld[d] = n_vld[d];
      e_res[d] = n_res[d];
      e_ovf[d] = n_ovf[d];
      e_tag[d] = n_tag[d];
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; req_valid = 2'b11;
    aluop0 = 4'd0; aluop1 = 4'd0; op1_0 = 32'sd1; op1_1 = 32'sd2; op2_0 = 32'sd3; op2_1 = 32'sd4;
    shamt0 = 5'd0; shamt1 = 5'd0; tag0 = 4'd1; tag1 = 4'd2;
    for (int i = 0; i < 2; i++) begin
      #2;
      total++;
      if (ready_a !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", ready_a); end
      clk_step();
      total++;
      if (rsp_valid_a !== 2'b00 || result_a !== 32'sd0 || ovf_a !== 1'b0 || tag_a !== 4'd0) begin
        bad++;
        $display("FAIL reset_rsp got vld=%b res=%h ovf=%b tag=%h want all zero", rsp_valid_a, result_a, ovf_a, tag_a);
      end
    end
    reset = 1'b0;
    #2;
    total++;
    if (ready_a !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b want=01", ready_a); end
    clk_step();
  endtask

  task automatic test_single_slot();
    req_valid = 2'b10; aluop1 = 4'd0; op1_1 = 32'sh7FFF_FFFF; op2_1 = 32'sd1; tag1 = 4'd3;
    #2;
    total++;
    if (ready_a !== 2'b10) begin bad++; $display("FAIL single_ready got=%b want=10", ready_a); end
    clk_step();
    req_valid = 2'b00;
    total++;
    if (rsp_valid_a !== 2'b10 || result_a !== 32'sh8000_0000 || ovf_a !== 1'b1 || tag_a !== 4'd3) begin
      bad++;
      $display("FAIL single_rsp got vld=%b res=%h ovf=%b tag=%h want vld=10 res=80000000 ovf=1 tag=3",
               rsp_valid_a, result_a, ovf_a, tag_a);
    end
  endtask

  task automatic test_contention();
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    req_valid = 2'b11; aluop0 = 4'd4; aluop1 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tag0 = 4'(i); tag1 = 4'(i + 8);
      op1_0 = signed'(rnd32()); op2_0 = signed'(rnd32()); op1_1 = signed'(rnd32()); op2_1 = signed'(rnd32());
      #2;
      total++;
      if (ready_a !== seq[i]) begin bad++; $display("FAIL contention_ready[%0d] got=%b want=%b", i, ready_a, seq[i]); end
      total++;
      if (ready_b !== 2'b01) begin bad++; $display("FAIL fixed_ready[%0d] got=%b want=01", i, ready_b); end
      clk_step();
      total++;
      if (rsp_valid_a !== seq[i] || tag_a !== (seq[i][1] ? 4'(i + 8) : 4'(i)) || result_a !== signed'(e_res[0])) begin
        bad++;
        $display("FAIL contention_rsp[%0d] got vld=%b tag=%h res=%h want vld=%b res=%h", i, rsp_valid_a, tag_a,
                 result_a, seq[i], e_res[0]);
      end
      total++;
      if (rsp_valid_b !== 2'b01 || tag_b !== 4'(i)) begin
        bad++;
        $display("FAIL fixed_rsp[%0d] got vld=%b tag=%h want vld=01 tag=%h", i, rsp_valid_b, tag_b, 4'(i));
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_ops();
    logic [3:0]  t_op [7];
    logic [31:0] t_a  [7];
    logic [31:0] t_b  [7];
    logic [4:0]  t_sh [7];
    logic [31:0] t_r  [7];
    t_op[0] = 4'd1; t_a[0] = 32'd5;          t_b[0] = 32'd7;          t_sh[0] = 5'd0;  t_r[0] = 32'hFFFF_FFFE;
    t_op[1] = 4'd6; t_a[1] = 32'hFFFF_FFFF;  t_b[1] = 32'd1;          t_sh[1] = 5'd0;  t_r[1] = 32'd1;
    t_op[2] = 4'd8; t_a[2] = 32'd0;          t_b[2] = 32'h8000_0000;  t_sh[2] = 5'd31; t_r[2] = 32'd1;
    t_op[3] = 4'hF; t_a[3] = 32'd9;          t_b[3] = 32'd9;          t_sh[3] = 5'd3;  t_r[3] = 32'd0;
    t_op[4] = 4'd7; t_a[4] = 32'd0;          t_b[4] = 32'd1;          t_sh[4] = 5'd4;  t_r[4] = 32'd16;
    t_op[5] = 4'd9; t_a[5] = 32'd3;          t_b[5] = 32'hFFFF_FFFE;  t_sh[5] = 5'd0;  t_r[5] = 32'd1;
    t_op[6] = 4'd5; t_a[6] = 32'd0;          t_b[6] = 32'd0;          t_sh[6] = 5'd0;  t_r[6] = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) begin
      req_valid = 2'b01; aluop0 = t_op[i]; op1_0 = signed'(t_a[i]); op2_0 = signed'(t_b[i]);
      shamt0 = t_sh[i]; tag0 = 4'(i);
      #2;
      clk_step();
      total++;
      if (rsp_valid_a !== 2'b01 || result_a !== signed'(t_r[i])) begin
        bad++;
        $display("FAIL op[%0d] code=%h got vld=%b res=%h want vld=01 res=%h", i, t_op[i], rsp_valid_a, result_a, t_r[i]);
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_flush();
    req_valid = 2'b01; aluop0 = 4'd0; op1_0 = 32'sd10; op2_0 = 32'sd20; tag0 = 4'd5;
    #2;
    clk_step();
    req_valid = 2'b11; flush = 1'b1; tag1 = 4'd6;
    #2;
    total++;
    if (rsp_valid_a !== 2'b01 || result_a !== 32'sd30 || tag_a !== 4'd5) begin
      bad++;
      $display("FAIL flush_prior_op got vld=%b res=%h tag=%h want vld=01 res=1e tag=5", rsp_valid_a, result_a, tag_a);
    end
    total++;
    if (ready_a !== 2'b00 || ready_b !== 2'b00) begin
      bad++; $display("FAIL flush_ready got rr=%b fp=%b want 00", ready_a, ready_b);
    end
    clk_step();
    flush = 1'b0;
    total++;
    if (rsp_valid_a !== 2'b00 || result_a !== 32'sd30) begin
      bad++; $display("FAIL flush_drop got vld=%b res=%h want vld=00 res=1e", rsp_valid_a, result_a);
    end
    #2;
    total++;
    if (ready_a !== 2'b10) begin bad++; $display("FAIL flush_ptr_hold got=%b want=10", ready_a); end
    clk_step();
    req_valid = 2'b00;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 7) == 0);
      req_valid = 2'($urandom_range(0, 3));
      aluop0 = 4'($urandom_range(0, 15)); aluop1 = 4'($urandom_range(0, 15));
      op1_0 = signed'(rnd32()); op2_0 = signed'(rnd32());
      op1_1 = signed'(rnd32()); op2_1 = signed'(rnd32());
      shamt0 = 5'($urandom); shamt1 = 5'($urandom);
      tag0 = 4'($urandom); tag1 = 4'($urandom);
      #2;
      total++;
      if (ready_a !== model_gnt(req_valid, m_pref, flush, reset) || ready_b !== model_gnt(req_valid, 0, flush, reset)) begin
        bad++;
        $display("FAIL rand_ready[%0d] got rr=%b fp=%b want rr=%b fp=%b", i, ready_a, ready_b,
                 model_gnt(req_valid, m_pref, flush, reset), model_gnt(req_valid, 0, flush, reset));
      end
      clk_step();
      total++;
      if (rsp_valid_a !== e_vld[0] || result_a !== signed'(e_res[0]) || ovf_a !== e_ovf[0] || tag_a !== e_tag[0]) begin
        bad++;
        $display("FAIL rand_rsp_rr[%0d] got vld=%b res=%h ovf=%b tag=%h want vld=%b res=%h ovf=%b tag=%h", i,
                 rsp_valid_a, result_a, ovf_a, tag_a, e_vld[0], e_res[0], e_ovf[0], e_tag[0]);
      end
      total++;
      if (rsp_valid_b !== e_vld[1] || result_b !== signed'(e_res[1]) || ovf_b !== e_ovf[1] || tag_b !== e_tag[1]) begin
        bad++;
        $display("FAIL rand_rsp_fp[%0d] got vld=%b res=%h ovf=%b tag=%h want vld=%b res=%h ovf=%b tag=%h", i,
                 rsp_valid_b, result_b, ovf_b, tag_b, e_vld[1], e_res[1], e_ovf[1], e_tag[1]);
      end
    end
    reset = 1'b0; flush = 1'b0; req_valid = 2'b00;
  endtask

  initial begin
    m_pref = 0;
    for (int d = 0; d < 2; d++) begin
      e_vld[d] = 2'b00; e_res[d] = 32'h0; e_ovf[d] = 1'b0; e_tag[d] = 4'h0;
    end
    test_reset();
    test_single_slot();
    test_contention();
    test_ops();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
